// File: rtl/mono_fb_write_arbiter_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | mono_fb_write_arbiter_if                                                |
// | Dither write port, scanout read port and framebuffer RAM bus.           |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
interface mono_fb_write_arbiter_if #(
    parameter int ADDR_BITS = 14
);
    logic [15:0]          wr_bits;
    logic [11:0]          wr_xaddr;
    logic [11:0]          wr_yaddr;
    logic                 wr_strobe;
    logic                 vsync;
    logic                 freeze;
    logic                 rd_req;
    logic [ADDR_BITS-1:0] rd_addr;
    logic [15:0]          rd_data;
    logic                 rd_valid;
    logic [ADDR_BITS-1:0] ram_addr;
    logic [15:0]          ram_wdata;
    logic                 ram_we;
    logic [15:0]          ram_rdata;
    logic                 frozen;
    logic [7:0]           overflow_count;
    logic [15:0]          frame_count;

    modport master (
        output wr_bits, wr_xaddr, wr_yaddr, wr_strobe, vsync, freeze,
               rd_req, rd_addr, ram_rdata,
        input  rd_data, rd_valid, ram_addr, ram_wdata, ram_we,
               frozen, overflow_count, frame_count
    );

    modport slave (
        input  wr_bits, wr_xaddr, wr_yaddr, wr_strobe, vsync, freeze,
               rd_req, rd_addr, ram_rdata,
        output rd_data, rd_valid, ram_addr, ram_wdata, ram_we,
               frozen, overflow_count, frame_count
    );
endinterface
`default_nettype wire

// File: rtl/mono_fb_write_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | mono_fb_write_arbiter                                                   |
// | Shares a single-port mono framebuffer RAM between scanout reads         |
// | (always win) and FIFO-buffered dither writes, with per-frame freeze.    |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
module mono_fb_write_arbiter #(
    parameter int WIDTH      = 512,
    parameter int HEIGHT     = 342,
    parameter int ADDR_BITS  = 14,
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic              clk,
    input  wire logic              reset,
    mono_fb_write_arbiter_if.slave bus
);
    localparam int             WORDS_PER_LINE = WIDTH / 16;
    localparam int             PTR_W          = $clog2(FIFO_DEPTH);
    localparam logic [31:0]    C_WIDTH        = WIDTH;
    localparam logic [31:0]    C_HEIGHT       = HEIGHT;
    localparam logic [PTR_W:0] C_DEPTH        = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        FROZEN = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic                 stage_valid_q, stage_valid_d;
    logic                 stage_in_range_q, stage_in_range_d;
    logic [ADDR_BITS-1:0] stage_addr_q, stage_addr_d;
    logic [15:0]          stage_bits_q, stage_bits_d;
    logic [ADDR_BITS-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [ADDR_BITS-1:0] fifo_addr_d [FIFO_DEPTH];
    logic [15:0]          fifo_bits_q [FIFO_DEPTH];
    logic [15:0]          fifo_bits_d [FIFO_DEPTH];
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]       count_q, count_d;
    logic [ADDR_BITS-1:0] ram_addr_q, ram_addr_d;
    logic [15:0]          ram_wdata_q, ram_wdata_d;
    logic                 ram_we_q, ram_we_d;
    logic [1:0]           rd_pipe_q, rd_pipe_d;
    logic [7:0]           overflow_count_q, overflow_count_d;
    logic [15:0]          frame_count_q, frame_count_d;

    logic pop;
    logic accept;
    logic push;
    logic drop;

    always_comb begin
        state_d          = state_q;
        stage_valid_d    = bus.wr_strobe;
        stage_in_range_d = stage_in_range_q;
        stage_addr_d     = stage_addr_q;
        stage_bits_d     = stage_bits_q;
        fifo_addr_d      = fifo_addr_q;
        fifo_bits_d      = fifo_bits_q;
        rd_ptr_d         = rd_ptr_q;
        wr_ptr_d         = wr_ptr_q;
        count_d          = count_q;
        ram_addr_d       = ram_addr_q;
        ram_wdata_d      = ram_wdata_q;
        ram_we_d         = 1'b0;
        rd_pipe_d        = {rd_pipe_q[0], bus.rd_req};
        overflow_count_d = overflow_count_q;
        frame_count_d    = frame_count_q;

        if (bus.wr_strobe) begin
            stage_addr_d     = ADDR_BITS'(bus.wr_yaddr) * ADDR_BITS'(WORDS_PER_LINE)
                             + ADDR_BITS'(bus.wr_xaddr[11:4]);
            stage_in_range_d = ({20'd0, bus.wr_xaddr} < C_WIDTH) &&
                               ({20'd0, bus.wr_yaddr} < C_HEIGHT);
            stage_bits_d     = bus.wr_bits;
        end

        // A pop in the same cycle frees a slot, so a full FIFO can still accept.
        pop    = !bus.rd_req && (count_q != '0);
        accept = stage_valid_q && stage_in_range_q && (state_q == RUN);
        push   = accept && ((count_q != C_DEPTH) || pop);
        drop   = accept && !push;

        if (bus.rd_req) begin
            ram_addr_d = bus.rd_addr;
        end else if (pop) begin
            ram_addr_d  = fifo_addr_q[rd_ptr_q];
            ram_wdata_d = fifo_bits_q[rd_ptr_q];
            ram_we_d    = 1'b1;
            rd_ptr_d    = rd_ptr_q + 1'b1;
        end

        if (push) begin
            fifo_addr_d[wr_ptr_q] = stage_addr_q;
            fifo_bits_d[wr_ptr_q] = stage_bits_q;
            wr_ptr_d              = wr_ptr_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (drop && (overflow_count_q != 8'hFF)) begin
            overflow_count_d = overflow_count_q + 8'd1;
        end

        if (bus.vsync) begin
            frame_count_d = frame_count_q + 16'd1;
            case (state_q)
                RUN:     if (bus.freeze)  state_d = FROZEN;
                FROZEN:  if (!bus.freeze) state_d = RUN;
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= RUN;
            stage_valid_q    <= 1'b0;
            stage_in_range_q <= 1'b0;
            stage_addr_q     <= '0;
            stage_bits_q     <= '0;
            fifo_addr_q      <= '{default: '0};
            fifo_bits_q      <= '{default: '0};
            rd_ptr_q         <= '0;
            wr_ptr_q         <= '0;
            count_q          <= '0;
            ram_addr_q       <= '0;
            ram_wdata_q      <= '0;
            ram_we_q         <= 1'b0;
            rd_pipe_q        <= '0;
            overflow_count_q <= '0;
            frame_count_q    <= '0;
        end else begin
            state_q          <= state_d;
            stage_valid_q    <= stage_valid_d;
            stage_in_range_q <= stage_in_range_d;
            stage_addr_q     <= stage_addr_d;
            stage_bits_q     <= stage_bits_d;
            fifo_addr_q      <= fifo_addr_d;
            fifo_bits_q      <= fifo_bits_d;
            rd_ptr_q         <= rd_ptr_d;
            wr_ptr_q         <= wr_ptr_d;
            count_q          <= count_d;
            ram_addr_q       <= ram_addr_d;
            ram_wdata_q      <= ram_wdata_d;
            ram_we_q         <= ram_we_d;
            rd_pipe_q        <= rd_pipe_d;
            overflow_count_q <= overflow_count_d;
            frame_count_q    <= frame_count_d;
        end
    end

    assign bus.rd_data        = bus.ram_rdata;
    assign bus.rd_valid       = rd_pipe_q[1];
    assign bus.ram_addr       = ram_addr_q;
    assign bus.ram_wdata      = ram_wdata_q;
    assign bus.ram_we         = ram_we_q;
    assign bus.frozen         = (state_q == FROZEN);
    assign bus.overflow_count = overflow_count_q;
    assign bus.frame_count    = frame_count_q;
endmodule
`default_nettype wire
